// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Show-ahead byte FIFO that sits directly in front of the UART transmitter.
// The bus side pushes bytes with wr_en_i. The head entry is always presented
// on rd_data_o / rd_valid_o with no read latency. The transmitter pops the
// head by pulsing rd_consume_i when it launches a start bit.
//
// Parameters
//   DATA_W  entry width (the transmitter consumes 8)
//   DEPTH   number of entries, power of two, >= 2
//   AW      pointer width, derived from DEPTH
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   wr_en_i         write strobe, one entry per cycle
//   wr_data_i       write data
//   full_o          fill level == DEPTH
//   empty_o         fill level == 0
//   count_o         current fill level, 0..DEPTH
//   rd_valid_o      head entry available
//   rd_data_o       head entry, 0 when empty
//   rd_consume_i    pop strobe from the transmitter
//   flush_i         discard all entries
//   overflow_o      sticky, a write was dropped because the FIFO was full
//   clr_overflow_i  clears overflow_o (a simultaneous drop wins)
//
// Optional build macro UART_TX_FIFO_WATERMARK_EN adds:
//   watermark_i     low-water threshold
//   irq_o           registered level, 1 while fill level <= watermark_i
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              rd_consume_i,
  input  logic              flush_i,
  output logic              overflow_o,
  input  logic              clr_overflow_i
`ifdef UART_TX_FIFO_WATERMARK_EN
  ,
  input  logic [AW:0]       watermark_i,
  output logic              irq_o
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_next;
  logic              overflow_q;

  logic              wr_accept;
  logic              wr_drop;
  logic              rd_accept;

  // Full is judged on the pre-edge count only; a same-cycle pop does not
  // make room for the write.
  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;

  assign wr_accept = wr_en_i && !full_o;
  assign wr_drop   = wr_en_i && full_o;
  assign rd_accept = rd_consume_i && !empty_o;

  assign rd_valid_o = !empty_o;
  assign rd_data_o  = empty_o ? '0 : mem[rd_ptr_q];

  always_comb begin
    count_next = count_q;
    if (flush_i) begin
      count_next = '0;
    end else begin
      unique case ({wr_accept, rd_accept})
        2'b10:   count_next = count_q + (AW+1)'(1);
        2'b01:   count_next = count_q - (AW+1)'(1);
        default: count_next = count_q;
      endcase
    end
  end

  // Storage is deliberately not reset; count gates visibility.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && wr_accept) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_accept) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_next;
    end
  end

  // Overflow is independent of flush; a drop in the same cycle as a clear
  // keeps the flag set so the event is never lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (wr_drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow_i) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow_o = overflow_q;

`ifdef UART_TX_FIFO_WATERMARK_EN
  logic irq_q;

  // Evaluated on the post-update count so irq_o lines up with count_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= (count_next <= watermark_i);
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_en_i = 1'b0;
  logic [DATA_W-1:0] wr_data_i = '0;
  logic              full_o;
  logic              empty_o;
  logic [AW:0]       count_o;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_consume_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              overflow_o;
  logic              clr_overflow_i = 1'b0;
`ifdef UART_TX_FIFO_WATERMARK_EN
  logic [AW:0]       watermark_i = 5'd4;
  logic              irq_o;
`endif

  uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wr_en_i        (wr_en_i),
    .wr_data_i      (wr_data_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .count_o        (count_o),
    .rd_valid_o     (rd_valid_o),
    .rd_data_o      (rd_data_o),
    .rd_consume_i   (rd_consume_i),
    .flush_i        (flush_i),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
`ifdef UART_TX_FIFO_WATERMARK_EN
    ,
    .watermark_i    (watermark_i),
    .irq_o          (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of bytes expected at the head, in order.
  logic [7:0] sb_q [$];
  int m_count = 0;
  bit m_ovf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: whenever the transmitter side pops a valid head, compare it with
  // the oldest scoreboard entry.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rd_consume_i && rd_valid_o && !flush_i) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_pop", {24'd0, rd_data_o}, 32'hFFFF_FFFF);
        end else begin
          chk("pop_data", {24'd0, rd_data_o}, {24'd0, sb_q.pop_front()});
        end
      end
      if (!rd_valid_o) begin
        chk("idle_data_zero", {24'd0, rd_data_o}, 32'd0);
      end
    end
  end

  // One clock of stimulus. Inputs are applied just after a rising edge, the
  // model is advanced on the edge, and outputs are compared 1 time unit later.
  task automatic cyc(input bit we, input logic [7:0] wd, input bit cons,
                     input bit fl, input bit clr);
    bit pre_full, pre_empty;
    wr_en_i        = we;
    wr_data_i      = wd;
    rd_consume_i   = cons;
    flush_i        = fl;
    clr_overflow_i = clr;
    pre_full  = (m_count == DEPTH);
    pre_empty = (m_count == 0);
    @(posedge clk_i);
    if (we && pre_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    if (fl) begin
      m_count = 0;
      sb_q.delete();
    end else begin
      if (we && !pre_full) begin
        m_count++;
        sb_q.push_back(wd);
      end
      if (cons && !pre_empty) m_count--;
    end
    #1;
    wr_en_i = 1'b0; rd_consume_i = 1'b0; flush_i = 1'b0; clr_overflow_i = 1'b0;
    chk("count",    {27'd0, count_o},    m_count);
    chk("empty",    {31'd0, empty_o},    (m_count == 0));
    chk("full",     {31'd0, full_o},     (m_count == DEPTH));
    chk("valid",    {31'd0, rd_valid_o}, (m_count != 0));
    chk("overflow", {31'd0, overflow_o}, m_ovf);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    m_count = 0;
    m_ovf   = 1'b0;
    sb_q.delete();
    #1;
    rst_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (m_count == 0) break;
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_done", {27'd0, count_o}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_empty", {31'd0, empty_o},    32'd1);
    chk("rst_full",  {31'd0, full_o},     32'd0);
    chk("rst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_data",  {24'd0, rd_data_o},  32'd0);
    chk("rst_count", {27'd0, count_o},    32'd0);
    chk("rst_ovf",   {31'd0, overflow_o}, 32'd0);
`ifdef UART_TX_FIFO_WATERMARK_EN
    chk("rst_irq",   {31'd0, irq_o},      32'd1);
`endif

    // Single byte.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_valid", {31'd0, rd_valid_o}, 32'd1);
    chk("a5_data",  {24'd0, rd_data_o},  32'hA5);
    chk("a5_count", {27'd0, count_o},    32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("a5_empty", {31'd0, empty_o},    32'd1);
    chk("a5_zero",  {24'd0, rd_data_o},  32'd0);

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full",  {31'd0, full_o},  32'd1);
    chk("fill_count", {27'd0, count_o}, 32'd16);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf",   {31'd0, overflow_o}, 32'd1);
    chk("drop_count", {27'd0, count_o},    32'd16);
    chk("head_00",    {24'd0, rd_data_o},  32'h00);
    drain();

    // Full is not bypassed by a same-cycle pop.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", {31'd0, overflow_o}, 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpop_ovf",   {31'd0, overflow_o}, 32'd1);
    chk("fullpop_count", {27'd0, count_o},    32'd15);
    cyc(1'b1, 8'h60, 1'b1, 1'b0, 1'b0);
    chk("wrpop_count",   {27'd0, count_o},    32'd15);
    cyc(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    chk("wrpop_count2",  {27'd0, count_o},    32'd15);
    drain();

    // Pointer wrap: 8 in, 8 out, then 12 in.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    drain();
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    chk("wrap_count", {27'd0, count_o},   32'd12);
    chk("wrap_head",  {24'd0, rd_data_o}, 32'h30);
    drain();

    // Pop while empty is ignored.
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("empty_pop_count", {27'd0, count_o}, 32'd0);

    // Flush with a same-cycle write.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("flush_count", {27'd0, count_o}, 32'd0);
    chk("flush_empty", {31'd0, empty_o}, 32'd1);
    cyc(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    chk("post_flush_head", {24'd0, rd_data_o}, 32'h88);
    drain();

    // Clear and drop in the same cycle: set wins.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", {31'd0, overflow_o}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_alone",   {31'd0, overflow_o}, 32'd0);
    drain();

`ifdef UART_TX_FIFO_WATERMARK_EN
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    chk("irq_at6", {31'd0, irq_o}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("irq_at5", {31'd0, irq_o}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("irq_at4", {31'd0, irq_o}, 32'd1);
    drain();
`endif

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    do_reset();
    chk("midrst_count", {27'd0, count_o},    32'd0);
    chk("midrst_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("midrst_data",  {24'd0, rd_data_o},  32'd0);

    repeat (2) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Show-ahead byte FIFO placed directly upstream of the UART transmitter.
- Absorbs byte writes from the register/bus side.
- Presents the head byte with a valid flag. The head is popped when the transmitter pulses its consume output, which happens when it launches a start bit.
- Reports fill level, full/empty status and sticky overflow.

Parameters:
- DATA_W, 8, width of each stored entry; the transmitter consumes 8.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- wr_en_i  input  1  write strobe, one entry per cycle.
- wr_data_i  input  DATA_W  write data.
- full_o  output  1  count == DEPTH.
- empty_o  output  1  count == 0.
- count_o  output  AW+1  current fill level, 0..DEPTH.
- rd_valid_o  output  1  head entry available; drives the transmitter's data-valid input.
- rd_data_o  output  DATA_W  head entry; drives the transmitter's data input.
- rd_consume_i  input  1  pop strobe; driven by the transmitter's consume output.
- flush_i  input  1  discard all entries.
- overflow_o  output  1  sticky: a write was dropped.
- clr_overflow_i  input  1  clears overflow_o.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: rd_ptr=0, wr_ptr=0, count=0, overflow=0. Storage array is not reset.
- Outputs after reset: empty_o=1, full_o=0, rd_valid_o=0, rd_data_o=0, count_o=0, overflow_o=0.
- Reset mid-operation discards all contents and takes effect at the next clk_i edge.
- Storage: register array; rd_ptr and wr_ptr are AW bits and wrap naturally modulo DEPTH; count is a separate AW+1-bit register.
- Show-ahead read: rd_valid_o = (count != 0). rd_data_o = mem[rd_ptr] when count != 0, else 0. Both are combinational from registers; there is no read latency.
- Write accept: wr_en_i && !full_o, judged on the pre-edge count. The entry is stored at wr_ptr and wr_ptr increments. The entry becomes visible on rd_valid_o/rd_data_o one cycle after accept.
- Write when full: data is dropped, pointers and count unchanged, overflow set. This holds even if rd_consume_i is high in the same cycle; full is not bypassed.
- Pop: rd_consume_i && count != 0 increments rd_ptr. rd_consume_i while empty is ignored: no pointer motion, no error flag.
- Simultaneous accepted write and pop: both pointers advance, count unchanged.
- Priority per cycle: rst_i > flush_i > write/pop.
- flush_i: rd_ptr=wr_ptr=0 and count=0. Any write or pop in the same cycle is discarded. overflow is unaffected.
- overflow: set by a dropped write; cleared by clr_overflow_i. If both occur in the same cycle, set wins.
- Transmitter coupling: the transmitter asserts consume for exactly one cycle per byte, in its idle state. The byte presented on rd_data_o in that cycle is the one transmitted. The next head becomes visible combinationally in the following cycle.

Optional Feature:
- Macro: UART_TX_FIFO_WATERMARK_EN.
- When defined:
  - Add input watermark_i (AW+1 bits) and output irq_o.
  - irq_o is a registered level: at each edge it is set to (count_next <= watermark_i), evaluated on the post-update count.
  - irq_o resets to 1, since count is 0.
  - watermark_i == 0 asserts irq_o only when empty.
  - watermark_i >= DEPTH keeps irq_o permanently 1.
- When undefined: neither port exists and there is no added logic.

Test Plan:
- Reset, then write 0xA5 in a single cycle -> rd_valid_o=1 and rd_data_o=0xA5 on the next cycle; count_o=1. Pulse rd_consume_i once -> empty_o=1, rd_data_o=0 the cycle after.
- Write 16 bytes 0x00..0x0F back-to-back -> full_o=1, count_o=16. 17th write of 0xFF -> dropped, overflow_o=1. Drain all -> bytes read out 0x00..0x0F in order, 0xFF absent.
- Fill to 16, then assert write 0x55 and rd_consume_i in the same cycle -> 0x55 dropped, overflow_o=1, count_o=15. When not full, simultaneous write+pop -> count_o unchanged, order preserved.
- Fill 8 entries, drain 8, then fill 12 (pointer wrap) -> output order matches input order, and count_o tracks exactly each cycle.
- With 5 entries, assert flush_i together with a write of 0x77 -> count_o=0, empty_o=1, 0x77 not stored. Separately, assert clr_overflow_i in the same cycle as a dropped write -> overflow_o stays 1.
- With UART_TX_FIFO_WATERMARK_EN and watermark_i=4: fill to 6 -> irq_o=0. Pop to 4 -> irq_o=1 on the edge after the pop completing count 4. Connect to the transmitter (baud divisor 3) -> the serial line carries the bytes in FIFO order.
